// File: rtl/parameters_pkg.sv
// Shared async-FIFO sizing constants and pointer encoding helper.
// Pure declarations: no latency, no flow control.
// Used by both the write-side and read-side pointer blocks.
package parameters_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int AF_MARGIN  = 2;

    // Callers cast the argument up and the result back down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter, width-parameterized.
// Combinational, zero latency; no flow control.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = gray;
        for (int i = 1; i < WIDTH; i++) begin
            bin = bin ^ (gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Async-FIFO write pointer, Gray pointer export, full/overflow flags (almost-full under FIFO_ALMOST_FULL_EN).
// Pointer and flags are registered, 1 clk; w_en is combinational from w_inc and w_full.
// Writes while full are dropped and latched into sticky w_ovf; w_full releases 1 clk after rq2_rptr moves.
module fifo_wr_ptr_full #(
    parameter int ADDR_WIDTH = parameters_pkg::ADDR_WIDTH,
    parameter int PTR_WIDTH  = parameters_pkg::PTR_WIDTH,
    parameter int AF_MARGIN  = parameters_pkg::AF_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_inc,
    input  logic [PTR_WIDTH-1:0]  rq2_rptr,
    input  logic                  w_ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [PTR_WIDTH-1:0]  wptr_gray,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic                  w_ovf
);

    import parameters_pkg::bin2gray;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (PTR_WIDTH != ADDR_WIDTH + 1 || AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_param_check
        $error("fifo_wr_ptr_full: inconsistent ADDR_WIDTH/PTR_WIDTH/AF_MARGIN");
    end

    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] wbin_next;
    logic [PTR_WIDTH-1:0] wgray_next;
    logic [PTR_WIDTH-1:0] rptr_full_pattern;
    logic                 full_cond;

    assign w_en       = w_inc & ~w_full;
    assign wbin_next  = wbin + PTR_WIDTH'(w_en);
    assign wgray_next = PTR_WIDTH'(bin2gray(32'(wbin_next)));

    // Full when the write pointer has lapped the read pointer by exactly one pass:
    // in Gray code that is the top two bits inverted, the rest equal.
    assign rptr_full_pattern = {~rq2_rptr[PTR_WIDTH-1 -: 2], rq2_rptr[PTR_WIDTH-3:0]};
    assign full_cond         = (wgray_next == rptr_full_pattern);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            w_addr    <= '0;
            w_full    <= 1'b0;
            w_ovf     <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            w_addr    <= wbin_next[ADDR_WIDTH-1:0];
            w_full    <= full_cond;
            if (w_inc && w_full) begin
                w_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                w_ovf <= 1'b0;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] fill_next;

    gray2bin #(
        .WIDTH (PTR_WIDTH)
    ) u_rptr_g2b (
        .gray (rq2_rptr),
        .bin  (rbin)
    );

    // Modular subtraction stays correct across pointer wrap.
    assign fill_next = wbin_next - rbin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_almost_full <= 1'b0;
        end else begin
            w_almost_full <= (fill_next >= PTR_WIDTH'(DEPTH - AF_MARGIN));
        end
    end
`else
    assign w_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Self-checking bench for fifo_wr_ptr_full: directed vector table, corner sequences,
// and randomized traffic against a count-based model.
module tb_fifo_wr_ptr_full;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_inc = 1'b0;
    logic [3:0] rq2_rptr = 4'd0;
    logic       w_ovf_clr = 1'b0;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] wptr_gray;
    logic       w_full;
    logic       w_almost_full;
    logic       w_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_wr_ptr_full #(
        .ADDR_WIDTH (3),
        .PTR_WIDTH  (4),
        .AF_MARGIN  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_inc         (w_inc),
        .rq2_rptr      (rq2_rptr),
        .w_ovf_clr     (w_ovf_clr),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .wptr_gray     (wptr_gray),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_ovf         (w_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w_inc;
        logic [3:0] rq2;
        logic       clr;
        logic       exp_en;
        logic [2:0] exp_addr;
        logic [3:0] exp_gray;
        logic       exp_full;
        logic       exp_ovf;
        int         fill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] gray_of(input int count);
        logic [3:0] b;
        b = count[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic af_of(input int fill);
`ifdef FIFO_ALMOST_FULL_EN
        return fill >= DEPTH - 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic add(input logic wi, input logic [3:0] rq, input logic cl, input logic en,
                       input int addr, input logic [3:0] gr, input logic fu, input logic ov,
                       input int fill);
        vec_t v;
        v.w_inc = wi; v.rq2 = rq; v.clr = cl; v.exp_en = en;
        v.exp_addr = addr[2:0]; v.exp_gray = gr; v.exp_full = fu; v.exp_ovf = ov; v.fill = fill;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        w_inc = 1'b0; w_ovf_clr = 1'b0; rq2_rptr = 4'd0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, check w_en before the edge, return after the edge.
    task automatic step(input logic wi, input logic [3:0] rq, input logic cl,
                        input logic exp_en, input string tag);
        @(negedge clk);
        w_inc = wi; rq2_rptr = rq; w_ovf_clr = cl;
        #1 chk({tag, ".w_en"}, w_en, exp_en);
        @(posedge clk);
        #1;
    endtask

    int wcnt, rcnt;
    logic full_m, ovf_m, af_m, wi_r, cl_r, en_m;

    initial begin
        // Asynchronous reset from power-up
        #2 rst = 1'b0;
        #1;
        chk("por.w_addr", w_addr, 0);
        chk("por.wptr_gray", wptr_gray, 0);
        chk("por.w_full", w_full, 0);
        chk("por.w_ovf", w_ovf, 0);
        chk("por.w_almost_full", w_almost_full, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fill, overflow, clear, drain, wrap, simultaneous read-update
        for (int k = 0; k < 8; k++) add(1, 4'd0, 0, 1, (k + 1) % 8, gray_of(k + 1), k == 7, 0, k + 1);
        add(1, 4'd0,    0, 0, 0, 4'b1100, 1, 1, 8);
        add(0, 4'd0,    1, 0, 0, 4'b1100, 1, 0, 8);
        add(0, 4'b1100, 0, 0, 0, 4'b1100, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(1, 4'b1100, 0, 1, (k + 1) % 8, gray_of(9 + k), k == 7, 0, k + 1);
        add(1, 4'b1101, 0, 0, 0, 4'b0000, 0, 1, 7);
        add(1, 4'b1101, 0, 1, 1, 4'b0001, 1, 1, 8);
        add(1, 4'b1101, 1, 0, 1, 4'b0001, 1, 1, 8);
        add(0, 4'b1101, 1, 0, 1, 4'b0001, 1, 0, 8);

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].w_inc, vecs[i].rq2, vecs[i].clr, vecs[i].exp_en, t);
            chk({t, ".w_addr"}, w_addr, vecs[i].exp_addr);
            chk({t, ".wptr_gray"}, wptr_gray, vecs[i].exp_gray);
            chk({t, ".w_full"}, w_full, vecs[i].exp_full);
            chk({t, ".w_ovf"}, w_ovf, vecs[i].exp_ovf);
            chk({t, ".w_almost_full"}, w_almost_full, af_of(vecs[i].fill));
        end

        // Reset asserted mid-cycle while writing: outputs clear without a clock edge
        step(1, 4'b1101, 0, 0, "prerst");
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst.w_addr", w_addr, 0);
        chk("midrst.wptr_gray", wptr_gray, 0);
        chk("midrst.w_full", w_full, 0);
        chk("midrst.w_ovf", w_ovf, 0);
        chk("midrst.w_en", w_en, 1);
        @(negedge clk);
        w_inc = 1'b0; rq2_rptr = 4'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst.w_addr", w_addr, 0);
        chk("postrst.wptr_gray", wptr_gray, 0);

        // Almost-full threshold and release
        for (int k = 1; k <= 6; k++) begin
            step(1, 4'd0, 0, 1, $sformatf("af_w%0d", k));
            if (k >= 5) chk($sformatf("af_w%0d.w_almost_full", k), w_almost_full, af_of(k));
        end
        step(0, 4'b0001, 0, 0, "af_rd");
        chk("af_rd.w_almost_full", w_almost_full, af_of(5));
        chk("af_rd.w_full", w_full, 0);

        // Randomized traffic against a count-based model
        do_reset();
        wcnt = 0; rcnt = 0; full_m = 0; ovf_m = 0; af_m = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            wi_r = ($urandom_range(3) != 0);
            cl_r = ($urandom_range(7) == 0);
            if (rcnt < wcnt && $urandom_range(1) == 1) rcnt++;
            w_inc = wi_r; w_ovf_clr = cl_r; rq2_rptr = gray_of(rcnt);
            en_m = wi_r && !full_m;
            #1 chk("rnd.w_en", w_en, en_m);
            @(posedge clk);
            ovf_m  = (wi_r && full_m) ? 1'b1 : (cl_r ? 1'b0 : ovf_m);
            wcnt   = wcnt + (en_m ? 1 : 0);
            full_m = (wcnt - rcnt) == DEPTH;
            af_m   = af_of(wcnt - rcnt);
            #1;
            chk("rnd.w_addr", w_addr, wcnt % DEPTH);
            chk("rnd.wptr_gray", wptr_gray, gray_of(wcnt));
            chk("rnd.w_full", w_full, full_m);
            chk("rnd.w_ovf", w_ovf, ovf_m);
            chk("rnd.w_almost_full", w_almost_full, af_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
